// File: rtl/tri_cmd_loader.sv
// Byte-serial triangle loader: XOR-checked packet -> staging bank -> active bank on frame_start.
// Latency: pending on the chk-byte edge, active on the edge after frame_start; no backpressure, din_valid is never stalled.
module tri_cmd_loader #(
    parameter int          TIMEOUT = 1023,
    parameter logic [7:0]  HDR     = 8'hA5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] din,
    input  logic       din_valid,
    input  logic       frame_start,
    output logic [9:0] v0_x,
    output logic [9:0] v0_y,
    output logic [9:0] v1_x,
    output logic [9:0] v1_y,
    output logic [9:0] v2_x,
    output logic [9:0] v2_y,
    output logic [5:0] color,
    output logic       tri_valid,
    output logic       pending,
    output logic [3:0] err_count
);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_PAYLOAD, S_CHECK} state_t;

    state_t           state_q, state_d;
    logic [3:0]       idx_q, idx_d;
    logic [7:0]       xor_q, xor_d;
    logic [9:0][7:0]  tmp_q, tmp_d;
    logic [TW-1:0]    tmo_q, tmo_d;
    logic [65:0]      stg_q, stg_d;
    logic [65:0]      act_q, act_d;
    logic             pending_q, pending_d;
    logic             tri_valid_q, tri_valid_d;
    logic [3:0]       err_q, err_d;
    logic             accept, drop;
    logic [65:0]      tmp_tri;

    // Bank layout: {x0,y0,x1,y1,x2,y2,colour}; hi bytes carry x[9:8] in [1:0], y[9:8] in [5:4].
    assign tmp_tri = {tmp_q[2][1:0], tmp_q[0], tmp_q[2][5:4], tmp_q[1],
                      tmp_q[5][1:0], tmp_q[3], tmp_q[5][5:4], tmp_q[4],
                      tmp_q[8][1:0], tmp_q[6], tmp_q[8][5:4], tmp_q[7],
                      tmp_q[9][5:0]};

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        xor_d       = xor_q;
        tmp_d       = tmp_q;
        tmo_d       = tmo_q;
        stg_d       = stg_q;
        act_d       = act_q;
        pending_d   = pending_q;
        tri_valid_d = tri_valid_q;
        err_d       = err_q;
        accept      = 1'b0;
        drop        = 1'b0;

        case (state_q)
            S_IDLE: begin
                tmo_d = '0;
                if (din_valid && din == HDR) begin
                    state_d = S_PAYLOAD;
                    idx_d   = '0;
                    xor_d   = '0;
                end
            end
            S_PAYLOAD, S_CHECK: begin
                if (din_valid) begin
                    tmo_d = '0;
                    if (state_q == S_PAYLOAD) begin
                        tmp_d[idx_q] = din;
                        xor_d        = xor_q ^ din;
                        idx_d        = idx_q + 4'd1;
                        if (idx_q == 4'd9)
                            state_d = S_CHECK;
                    end else begin
                        state_d = S_IDLE;
                        accept  = (din == xor_q);
                        drop    = (din != xor_q);
                    end
                end else if (tmo_q == TW'(TIMEOUT)) begin
                    // A byte on the expiry cycle wins (handled above), so this only fires on silence.
                    state_d = S_IDLE;
                    tmo_d   = '0;
                    drop    = 1'b1;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Swap reads the old staging bank; a same-cycle accept re-arms pending for the next frame.
        if (frame_start && pending_q) begin
            act_d       = stg_q;
            tri_valid_d = 1'b1;
            pending_d   = 1'b0;
        end
        if (accept) begin
            stg_d     = tmp_tri;
            pending_d = 1'b1;
        end
        if (drop && err_q != 4'hF)
            err_d = err_q + 4'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            xor_q       <= '0;
            tmp_q       <= '0;
            tmo_q       <= '0;
            stg_q       <= '0;
            act_q       <= '0;
            pending_q   <= 1'b0;
            tri_valid_q <= 1'b0;
            err_q       <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            xor_q       <= xor_d;
            tmp_q       <= tmp_d;
            tmo_q       <= tmo_d;
            stg_q       <= stg_d;
            act_q       <= act_d;
            pending_q   <= pending_d;
            tri_valid_q <= tri_valid_d;
            err_q       <= err_d;
        end
    end

    assign {v0_x, v0_y, v1_x, v1_y, v2_x, v2_y, color} = act_q;
    assign tri_valid = tri_valid_q;
    assign pending   = pending_q;
    assign err_count = err_q;
endmodule

// File: tb/tb_tri_cmd_loader.sv
// Scoreboard bench for tri_cmd_loader: expected active triangles queued at frame swaps.
module tb_tri_cmd_loader;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] din = 8'h00;
    logic       din_valid = 1'b0;
    logic       frame_start = 1'b0;
    logic [9:0] v0_x, v0_y, v1_x, v1_y, v2_x, v2_y;
    logic [5:0] color;
    logic       tri_valid, pending;
    logic [3:0] err_count;
    logic [65:0] obs;

    int checks = 0;
    int failures = 0;

    logic [65:0] exp_q[$];
    logic [65:0] m_stg, m_act, exp_tri;
    logic        m_pending;
    logic [3:0]  m_err;

    tri_cmd_loader dut (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
        .frame_start(frame_start),
        .v0_x(v0_x), .v0_y(v0_y), .v1_x(v1_x), .v1_y(v1_y), .v2_x(v2_x), .v2_y(v2_y),
        .color(color), .tri_valid(tri_valid), .pending(pending), .err_count(err_count)
    );

    always #5 clk = ~clk;
    assign obs = {v0_x, v0_y, v1_x, v1_y, v2_x, v2_y, color};

    function automatic logic [65:0] decode(input logic [9:0][7:0] p);
        logic [65:0] r;
        r = '0;
        for (int k = 0; k < 3; k++) begin
            r[65 - 20*k -: 10] = {p[3*k+2][1:0], p[3*k]};
            r[55 - 20*k -: 10] = {p[3*k+2][5:4], p[3*k+1]};
        end
        r[5:0] = p[9][5:0];
        return r;
    endfunction

    function automatic logic [7:0] csum(input logic [9:0][7:0] p);
        logic [7:0] x;
        x = 8'h00;
        for (int i = 0; i < 10; i++) x ^= p[i];
        return x;
    endfunction

    function automatic logic [9:0][7:0] good_pkt();
        logic [9:0][7:0] p;
        p[0] = 8'h10; p[1] = 8'h20; p[2] = 8'h00;
        p[3] = 8'h9F; p[4] = 8'h30; p[5] = 8'h11;
        p[6] = 8'hFF; p[7] = 8'hFF; p[8] = 8'h33;
        p[9] = 8'h2A;
        return p;
    endfunction

    function automatic logic [9:0][7:0] rand_pkt();
        logic [9:0][7:0] p;
        for (int i = 0; i < 10; i++) p[i] = 8'($urandom_range(0, 255));
        return p;
    endfunction

    task automatic send_byte(input logic [7:0] b);
        din = b;
        din_valid = 1'b1;
        @(posedge clk); #1;
        din_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        m_stg = '0; m_act = '0; m_pending = 1'b0; m_err = 4'd0;
        exp_q.delete();
    endtask

    task automatic frame_pulse();
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
        if (m_pending) begin
            exp_q.push_back(m_stg);
            m_act = m_stg;
            m_pending = 1'b0;
        end
    endtask

    task automatic send_packet(input logic [9:0][7:0] p, input logic [7:0] flip, input bit fs_on_chk);
        send_byte(8'hA5);
        for (int i = 0; i < 10; i++) send_byte(p[i]);
        frame_start = fs_on_chk;
        if (fs_on_chk && m_pending) begin
            exp_q.push_back(m_stg);
            m_act = m_stg;
            m_pending = 1'b0;
        end
        send_byte(csum(p) ^ flip);
        frame_start = 1'b0;
        if (flip == 8'h00) begin
            m_stg = decode(p);
            m_pending = 1'b1;
        end else if (m_err != 4'hF) begin
            m_err = m_err + 4'd1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (obs !== 66'd0) begin failures++; $display("FAIL reset_active got=%h exp=0", obs); end
        checks++; if ({tri_valid, pending} !== 2'b00) begin failures++; $display("FAIL reset_flags got=%b exp=00", {tri_valid, pending}); end
        checks++; if (err_count !== 4'd0) begin failures++; $display("FAIL reset_err got=%0d exp=0", err_count); end
        do_reset();
    endtask

    task automatic test_bad_chk();
        do_reset();
        send_packet(good_pkt(), 8'h01, 1'b0);
        checks++; if (err_count !== 4'd1) begin failures++; $display("FAIL bad_err got=%0d exp=1", err_count); end
        checks++; if (pending !== 1'b0) begin failures++; $display("FAIL bad_pending got=%b exp=0", pending); end
        frame_pulse();
        checks++; if (obs !== 66'd0 || tri_valid !== 1'b0) begin failures++; $display("FAIL bad_active got=%h tv=%b exp=0 tv=0", obs, tri_valid); end
    endtask

    task automatic test_good();
        do_reset();
        send_packet(good_pkt(), 8'h00, 1'b0);
        checks++; if (pending !== 1'b1 || tri_valid !== 1'b0) begin failures++; $display("FAIL good_pending got=%b tv=%b exp=1 tv=0", pending, tri_valid); end
        checks++; if (obs !== 66'd0) begin failures++; $display("FAIL good_early_active got=%h exp=0", obs); end
        frame_pulse();
        if (exp_q.size() == 0) begin checks++; failures++; $display("FAIL good_queue got=empty exp=entry"); end
        else begin
            exp_tri = exp_q.pop_front();
            checks++; if (obs !== exp_tri) begin failures++; $display("FAIL good_active got=%h exp=%h", obs, exp_tri); end
        end
        checks++;
        if (obs !== {10'd16, 10'd32, 10'd415, 10'd304, 10'd1023, 10'd1023, 6'h2A}) begin
            failures++; $display("FAIL good_literal got=%h", obs);
        end
        checks++; if (tri_valid !== 1'b1 || pending !== 1'b0) begin failures++; $display("FAIL good_flags got tv=%b p=%b exp tv=1 p=0", tri_valid, pending); end
    endtask

    task automatic test_timeout(input int gap, input bit expect_drop);
        logic [9:0][7:0] p;
        p = good_pkt();
        do_reset();
        send_byte(8'hA5);
        for (int i = 0; i < 4; i++) send_byte(p[i]);
        repeat (gap) @(posedge clk);
        #1;
        for (int i = 4; i < 10; i++) send_byte(p[i]);
        send_byte(csum(p));
        checks++; if (err_count !== (expect_drop ? 4'd1 : 4'd0)) begin failures++; $display("FAIL timeout_err gap=%0d got=%0d exp=%0d", gap, err_count, expect_drop ? 1 : 0); end
        checks++; if (pending !== !expect_drop) begin failures++; $display("FAIL timeout_pending gap=%0d got=%b exp=%b", gap, pending, !expect_drop); end
    endtask

    task automatic test_back_to_back();
        logic [9:0][7:0] pa, pb;
        pa = rand_pkt();
        pb = rand_pkt();
        do_reset();
        send_packet(pa, 8'h00, 1'b0);
        send_packet(pb, 8'h00, 1'b0);
        checks++; if (pending !== 1'b1) begin failures++; $display("FAIL b2b_pending got=%b exp=1", pending); end
        frame_pulse();
        if (exp_q.size() == 0) begin checks++; failures++; $display("FAIL b2b_queue got=empty exp=entry"); end
        else begin
            exp_tri = exp_q.pop_front();
            checks++; if (obs !== exp_tri) begin failures++; $display("FAIL b2b_overwrite got=%h exp=%h", obs, exp_tri); end
        end
        do_reset();
        send_packet(pa, 8'h00, 1'b0);
        send_packet(pb, 8'h00, 1'b1);
        if (exp_q.size() == 0) begin checks++; failures++; $display("FAIL b2b_same_queue got=empty exp=entry"); end
        else begin
            exp_tri = exp_q.pop_front();
            checks++; if (obs !== exp_tri) begin failures++; $display("FAIL b2b_same_cycle got=%h exp=%h", obs, exp_tri); end
        end
        checks++; if (pending !== 1'b1) begin failures++; $display("FAIL b2b_same_pending got=%b exp=1", pending); end
        frame_pulse();
        if (exp_q.size() == 0) begin checks++; failures++; $display("FAIL b2b_next_queue got=empty exp=entry"); end
        else begin
            exp_tri = exp_q.pop_front();
            checks++; if (obs !== exp_tri) begin failures++; $display("FAIL b2b_next_frame got=%h exp=%h", obs, exp_tri); end
        end
    endtask

    task automatic test_reset_mid();
        logic [9:0][7:0] p;
        p = good_pkt();
        do_reset();
        send_byte(8'hA5);
        for (int i = 0; i < 5; i++) send_byte(p[i]);
        do_reset();
        send_packet(p, 8'h00, 1'b0);
        checks++; if (err_count !== 4'd0) begin failures++; $display("FAIL rstmid_err got=%0d exp=0", err_count); end
        checks++; if (pending !== 1'b1) begin failures++; $display("FAIL rstmid_pending got=%b exp=1", pending); end
    endtask

    task automatic test_saturate();
        logic [3:0] e;
        do_reset();
        for (int i = 0; i < 17; i++) begin
            send_packet(rand_pkt(), 8'h80, 1'b0);
            e = (i + 1 > 15) ? 4'd15 : 4'(i + 1);
            checks++; if (err_count !== e) begin failures++; $display("FAIL sat_err pkt=%0d got=%0d exp=%0d", i, err_count, e); end
        end
    endtask

    initial begin
        test_reset();
        test_bad_chk();
        test_good();
        test_timeout(1024, 1'b1);
        test_timeout(1023, 1'b0);
        test_back_to_back();
        test_reset_mid();
        test_saturate();
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL queue_drain got=%0d exp=0", exp_q.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
